dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Arbitrates the single data port of the program/data RAM between the CPU data bus and a host loader port used for quick RAM updates while the core runs. It sits between the CPU data-bus decode (RAM-space commands only; peripheral space is decoded upstream) and the RAM data-port pins. The RAM's instruction read port is not touched. Default sharing is round-robin. The loader can also lock the port exclusively, stalling CPU data accesses for bulk reloads.

## Interface
- ADDR_BITS, 11, byte-address width of RAM space (RAM depth is 2^(ADDR_BITS-2) words)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cpu_cmd_valid  in  1  CPU command request
- cpu_cmd_ready  out  1  CPU command accepted this cycle
- cpu_cmd_wr  in  1  1 = write, 0 = read
- cpu_cmd_addr  in  ADDR_BITS  byte address; bits [1:0] ignored
- cpu_cmd_wdata  in  32  write data
- cpu_cmd_be  in  4  byte enables
- cpu_rsp_valid  out  1  CPU read data valid
- cpu_rsp_rdata  out  32  CPU read data
- ld_cmd_valid, ld_cmd_ready, ld_cmd_wr, ld_cmd_addr, ld_cmd_wdata, ld_cmd_be  same directions/widths as the cpu_cmd_* ports  loader command
- ld_rsp_valid  out  1  loader read data valid
- ld_rsp_rdata  out  32  loader read data
- ld_lock  in  1  loader requests exclusive ownership
- ld_locked  out  1  exclusive ownership held
- mem_addr  out  ADDR_BITS-2  RAM word address
- mem_wr  out  4  per-byte write strobes
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after the address (synchronous, write-first)

## Operation
- Command phase is combinational. At most one of cpu_cmd_ready and ld_cmd_ready is high in a cycle, and only when the matching valid is high.
- A command is accepted on valid && ready.
- The granted command drives mem_addr = addr[ADDR_BITS-1:2].
- mem_wr = {4{wr}} & be for the granted command. mem_wr = 0 when nothing is granted.
- mem_addr holds its last value when idle.
- Round-robin pointer last_owner (register, CPU or LD):
  - When both valids are high, the grant goes to the requester that is not last_owner.
  - A single requester is always granted.
  - last_owner updates only on an accepted command.
- Response routing:
  - rsp_owner and rsp_pending are registered on an accepted read.
  - The next cycle, the matching *_rsp_valid = 1.
  - *_rsp_rdata = mem_rdata whenever the corresponding rsp_valid is high; it is 0 otherwise.
  - Writes produce no response.
- Lock FSM states:
  - SHARED: round-robin as above. ld_lock=1 → DRAIN.
  - DRAIN: CPU is never granted; the loader may be granted. Leave DRAIN when no CPU read response is pending this cycle: → LOCKED. If ld_lock=0 → SHARED.
  - LOCKED: ld_locked=1. Only the loader is granted; cpu_cmd_ready=0. ld_lock=0 → SHARED, and last_owner is forced to LD so the CPU wins the next tie.
- Simultaneous events:
  - ld_lock rising in the same cycle as a CPU grant in SHARED: that CPU command completes normally, including its response in DRAIN.
  - Loader valid together with ld_lock rising: arbitrated normally.

## Timing
- Reset values:
  - cpu_cmd_ready=0, ld_cmd_ready=0
  - cpu_rsp_valid=0, ld_rsp_valid=0
  - rsp data=0, ld_locked=0
  - mem_wr=0, mem_addr=0, mem_wdata=0
  - state SHARED, last_owner=LD (CPU wins the first tie), rsp_pending=0
- Read latency: accept at cycle N → rsp_valid at N+1.
- Write takes effect in RAM at the N clock edge.
- Lock latency:
  - ld_lock sampled at N → DRAIN during N+1 → LOCKED with ld_locked=1 at N+2, or N+3 if a CPU read was accepted at N.
- Release: ld_lock low sampled at N → CPU may be granted at N+1.
- Reset asserted mid-transaction drops any pending response: no rsp_valid is produced after reset deasserts.
- Back-to-back accepts are permitted every cycle. Sustained contention alternates CPU, LD, CPU, LD, …

## Configuration
- DMEM_ARB_LOCK_EN defined: lock FSM present as described.
- DMEM_ARB_LOCK_EN undefined:
  - FSM removed; behaviour is permanently SHARED round-robin.
  - ld_lock ignored; ld_locked tied 0.

## Structure
- Package dmem_arb_pkg:
  - state enum (SHARED, DRAIN, LOCKED)
  - owner encoding (OWN_CPU=0, OWN_LD=1)
  - WORD_BYTES=4
- One sub-module, dmem_arb_rr2: 2-input round-robin grant with the last_owner register and update-on-accept, plus a mask input used by the lock FSM to block the CPU.
- Response tracking and the FSM live in the top of dmem_port_arbiter.

## Test plan
- CPU-only write addr 0x010 be 4'b0011 data 0xA5A5_1234, then read 0x010 → mem_wr=0011 in write cycle; cpu_rsp_valid next cycle after read; rdata low half 0x1234 (RAM model).
- Both valid from reset for 4 cycles → grants CPU, LD, CPU, LD; each read response routes only to its owner; other rsp_valid stays 0.
- CPU read accepted in cycle N with ld_lock rising at N → cpu_rsp_valid at N+1; ld_locked=1 at N+3; cpu_cmd_ready=0 from N+1 while cpu_cmd_valid held.
- In LOCKED, loader writes 0x7F0..0x7FC; then drop ld_lock → CPU read of 0x7F0 accepted the following cycle and returns the loader data.
- Assert reset while an LD read response is pending → all outputs 0 immediately; no ld_rsp_valid after deassert; first tie goes to CPU.
- Build without DMEM_ARB_LOCK_EN; hold ld_lock=1 with both valid → round-robin continues; ld_locked stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the RAM data-port arbiter.
//   lock_state_e : loader lock FSM states (SHARED, DRAIN, LOCKED)
//   owner_e      : port owner encoding (OWN_CPU=0, OWN_LD=1)
//   WORD_BYTES   : bytes per RAM word; WORD_OFF_BITS is the byte-offset width
//   wr_strobe()  : per-byte write strobes for a command
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SHARED = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned WORD_OFF_BITS = $clog2(WORD_BYTES);

    // Reads carry no strobes; writes strobe only the enabled bytes.
    function automatic logic [3:0] wr_strobe(input logic wr, input logic [3:0] be);
        return {4{wr}} & be;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
// Bundles the CPU command/response, loader command/response/lock and
// RAM data-port signals of the arbiter.
//   slave  : arbiter view (commands, ld_lock, mem_rdata in; ready,
//            responses, ld_locked and RAM address/strobes/data out)
//   master : environment view (CPU, loader and RAM side)
// Parameter ADDR_BITS: byte-address width of RAM space.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 11
) ();

    localparam int unsigned WORD_ADDR_BITS = ADDR_BITS - WORD_OFF_BITS;

    logic                      cpu_cmd_valid;
    logic                      cpu_cmd_ready;
    logic                      cpu_cmd_wr;
    logic [ADDR_BITS-1:0]      cpu_cmd_addr;
    logic [31:0]               cpu_cmd_wdata;
    logic [3:0]                cpu_cmd_be;
    logic                      cpu_rsp_valid;
    logic [31:0]               cpu_rsp_rdata;

    logic                      ld_cmd_valid;
    logic                      ld_cmd_ready;
    logic                      ld_cmd_wr;
    logic [ADDR_BITS-1:0]      ld_cmd_addr;
    logic [31:0]               ld_cmd_wdata;
    logic [3:0]                ld_cmd_be;
    logic                      ld_rsp_valid;
    logic [31:0]               ld_rsp_rdata;
    logic                      ld_lock;
    logic                      ld_locked;

    logic [WORD_ADDR_BITS-1:0] mem_addr;
    logic [3:0]                mem_wr;
    logic [31:0]               mem_wdata;
    logic [31:0]               mem_rdata;

    modport slave (
        input  cpu_cmd_valid, cpu_cmd_wr, cpu_cmd_addr, cpu_cmd_wdata, cpu_cmd_be,
        output cpu_cmd_ready, cpu_rsp_valid, cpu_rsp_rdata,
        input  ld_cmd_valid, ld_cmd_wr, ld_cmd_addr, ld_cmd_wdata, ld_cmd_be, ld_lock,
        output ld_cmd_ready, ld_rsp_valid, ld_rsp_rdata, ld_locked,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_cmd_valid, cpu_cmd_wr, cpu_cmd_addr, cpu_cmd_wdata, cpu_cmd_be,
        input  cpu_cmd_ready, cpu_rsp_valid, cpu_rsp_rdata,
        output ld_cmd_valid, ld_cmd_wr, ld_cmd_addr, ld_cmd_wdata, ld_cmd_be, ld_lock,
        input  ld_cmd_ready, ld_rsp_valid, ld_rsp_rdata, ld_locked,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_rr2.sv
// dmem_arb_rr2
// Two-input round-robin grant between CPU and loader.
//   clk, reset     : clock, asynchronous active-high reset
//   req_cpu_i      : CPU request
//   req_ld_i       : loader request
//   mask_cpu_i     : blocks the CPU request (lock FSM)
//   force_ld_i     : forces last_owner to LD (lock release)
//   gnt_cpu_o      : CPU granted (combinational)
//   gnt_ld_o       : loader granted (combinational)
// last_owner resets to LD so the CPU wins the first tie, and moves only
// when a grant is given (a grant always implies an accepted command).
module dmem_arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_cpu_i,
    input  logic req_ld_i,
    input  logic mask_cpu_i,
    input  logic force_ld_i,
    output logic gnt_cpu_o,
    output logic gnt_ld_o
);

    owner_e last_owner_q;
    owner_e last_owner_d;
    logic   req_cpu_s;

    // Grant selection: a tie goes to whichever side did not own last.
    always_comb begin
        req_cpu_s = req_cpu_i & ~mask_cpu_i;
        gnt_cpu_o = 1'b0;
        gnt_ld_o  = 1'b0;
        if (req_cpu_s && req_ld_i) begin
            if (last_owner_q == OWN_CPU) begin
                gnt_ld_o = 1'b1;
            end else begin
                gnt_cpu_o = 1'b1;
            end
        end else if (req_cpu_s) begin
            gnt_cpu_o = 1'b1;
        end else if (req_ld_i) begin
            gnt_ld_o = 1'b1;
        end else begin
            gnt_cpu_o = 1'b0;
            gnt_ld_o  = 1'b0;
        end
    end

    // last_owner next state: release override, else follow the grant.
    always_comb begin
        last_owner_d = last_owner_q;
        if (force_ld_i) begin
            last_owner_d = OWN_LD;
        end else if (gnt_cpu_o) begin
            last_owner_d = OWN_CPU;
        end else if (gnt_ld_o) begin
            last_owner_d = OWN_LD;
        end else begin
            last_owner_d = last_owner_q;
        end
    end

    // last_owner register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_LD;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single RAM data port between the CPU data bus and a host
// loader port. Round-robin by default; with the lock feature the loader
// can take the port exclusively after draining any CPU read response.
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : dmem_port_arbiter_if.slave (CPU cmd/rsp, loader cmd/rsp/lock,
//            RAM address/strobes/write data out, RAM read data in)
// Macro DMEM_ARB_LOCK_EN: when defined, the SHARED/DRAIN/LOCKED lock FSM
// is built; otherwise ld_lock is ignored and ld_locked is tied low.
// Command phase is combinational: ready, mem_addr, mem_wr and mem_wdata
// follow the granted command in the same cycle; all of them are held at
// their reset values while reset is asserted.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus
);

    localparam int unsigned WA = ADDR_BITS - WORD_OFF_BITS;

    logic          cpu_req_s;
    logic          ld_req_s;
    logic          gnt_cpu_s;
    logic          gnt_ld_s;
    logic          mask_cpu_s;
    logic          force_ld_s;
    logic          rd_acc_s;
    owner_e        acc_owner_s;
    logic [3:0]    mem_wr_s;
    logic [WA-1:0] mem_addr_d;
    logic [WA-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_d;
    logic [31:0]   mem_wdata_q;
    logic          rsp_pending_q;
    owner_e        rsp_owner_q;
    logic          cpu_rsp_valid_s;
    logic          ld_rsp_valid_s;
    logic          unused_s;

    // Requests are suppressed during reset so no grant can leak out.
    assign cpu_req_s = bus.cpu_cmd_valid & ~reset;
    assign ld_req_s  = bus.ld_cmd_valid  & ~reset;

    dmem_arb_rr2 u_rr2 (
        .clk        (clk),
        .reset      (reset),
        .req_cpu_i  (cpu_req_s),
        .req_ld_i   (ld_req_s),
        .mask_cpu_i (mask_cpu_s),
        .force_ld_i (force_ld_s),
        .gnt_cpu_o  (gnt_cpu_s),
        .gnt_ld_o   (gnt_ld_s)
    );

    // RAM-side mux: granted command drives the port, otherwise hold.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_s    = 4'b0000;
        rd_acc_s    = 1'b0;
        acc_owner_s = OWN_CPU;
        if (gnt_cpu_s) begin
            mem_addr_d  = bus.cpu_cmd_addr[ADDR_BITS-1:WORD_OFF_BITS];
            mem_wdata_d = bus.cpu_cmd_wdata;
            mem_wr_s    = wr_strobe(bus.cpu_cmd_wr, bus.cpu_cmd_be);
            rd_acc_s    = ~bus.cpu_cmd_wr;
            acc_owner_s = OWN_CPU;
        end else if (gnt_ld_s) begin
            mem_addr_d  = bus.ld_cmd_addr[ADDR_BITS-1:WORD_OFF_BITS];
            mem_wdata_d = bus.ld_cmd_wdata;
            mem_wr_s    = wr_strobe(bus.ld_cmd_wr, bus.ld_cmd_be);
            rd_acc_s    = ~bus.ld_cmd_wr;
            acc_owner_s = OWN_LD;
        end else begin
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
        end
    end

    assign bus.cpu_cmd_ready = gnt_cpu_s;
    assign bus.ld_cmd_ready  = gnt_ld_s;
    assign bus.mem_addr      = mem_addr_d;
    assign bus.mem_wr        = mem_wr_s;
    assign bus.mem_wdata     = mem_wdata_d;

    // Held RAM address/data and read-response tracking registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q    <= {WA{1'b0}};
            mem_wdata_q   <= 32'h0000_0000;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= OWN_CPU;
        end else begin
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rsp_pending_q <= rd_acc_s;
            rsp_owner_q   <= acc_owner_s;
        end
    end

    // Response routing: RAM data is only visible to the read's owner.
    assign cpu_rsp_valid_s   = rsp_pending_q & (rsp_owner_q == OWN_CPU);
    assign ld_rsp_valid_s    = rsp_pending_q & (rsp_owner_q == OWN_LD);
    assign bus.cpu_rsp_valid = cpu_rsp_valid_s;
    assign bus.ld_rsp_valid  = ld_rsp_valid_s;
    assign bus.cpu_rsp_rdata = cpu_rsp_valid_s ? bus.mem_rdata : 32'h0000_0000;
    assign bus.ld_rsp_rdata  = ld_rsp_valid_s  ? bus.mem_rdata : 32'h0000_0000;

`ifdef DMEM_ARB_LOCK_EN
    lock_state_e state_q;
    lock_state_e state_d;
    logic        locked_s;

    // Lock FSM next state. The CPU is blocked as soon as DRAIN is entered;
    // LOCKED waits until no CPU read response is still in flight.
    always_comb begin
        state_d    = state_q;
        mask_cpu_s = 1'b0;
        force_ld_s = 1'b0;
        locked_s   = 1'b0;
        case (state_q)
            SHARED: begin
                if (bus.ld_lock) begin
                    state_d = DRAIN;
                end else begin
                    state_d = SHARED;
                end
            end
            DRAIN: begin
                mask_cpu_s = 1'b1;
                if (!bus.ld_lock) begin
                    state_d = SHARED;
                end else if (!cpu_rsp_valid_s) begin
                    state_d = LOCKED;
                end else begin
                    state_d = DRAIN;
                end
            end
            LOCKED: begin
                mask_cpu_s = 1'b1;
                locked_s   = 1'b1;
                if (!bus.ld_lock) begin
                    state_d    = SHARED;
                    force_ld_s = 1'b1;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = SHARED;
            end
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SHARED;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.ld_locked = locked_s;
    assign unused_s      = ^{bus.cpu_cmd_addr[WORD_OFF_BITS-1:0],
                             bus.ld_cmd_addr[WORD_OFF_BITS-1:0]};
`else
    assign mask_cpu_s    = 1'b0;
    assign force_ld_s    = 1'b0;
    assign bus.ld_locked = 1'b0;
    assign unused_s      = ^{bus.cpu_cmd_addr[WORD_OFF_BITS-1:0],
                             bus.ld_cmd_addr[WORD_OFF_BITS-1:0], bus.ld_lock};
`endif

endmodule
